// File: rtl/alarm_scheduler_pkg.sv
// Shared types and time-field limits for the alarm scheduler and its helpers.
package alarm_scheduler_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;
   localparam int IDX_W  = 2;

   localparam logic [HOUR_W-1:0] MAX_HOUR      = 5'd23;
   localparam logic [MIN_W-1:0]  MAX_MIN       = 6'd59;
   localparam logic [SEC_W-1:0]  MAX_SEC       = 6'd59;
   localparam logic [MIN_W:0]    MINS_PER_HOUR = 7'd60;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_t;

   function automatic logic time_valid(input logic [HOUR_W-1:0] h,
                                       input logic [MIN_W-1:0]  m,
                                       input logic [SEC_W-1:0]  s);
      return (h <= MAX_HOUR) && (m <= MAX_MIN) && (s <= MAX_SEC);
   endfunction

endpackage

// File: rtl/alarm_scheduler_time_add_min.sv
// Combinational hour:minute + ADD_MIN minutes with 24-hour wrap (ADD_MIN <= 59).
module time_add_min
   import alarm_scheduler_pkg::*;
#(
   parameter int ADD_MIN = 5
) (
   input  logic [HOUR_W-1:0] hour_i,
   input  logic [MIN_W-1:0]  min_i,
   output logic [HOUR_W-1:0] hour_o,
   output logic [MIN_W-1:0]  min_o
);

   localparam logic [MIN_W:0] ADD = ADD_MIN[MIN_W:0];

   logic [MIN_W:0] min_sum;
   logic [MIN_W:0] min_wrap;

   always_comb begin
      min_sum  = {1'b0, min_i} + ADD;
      min_wrap = min_sum - MINS_PER_HOUR;
      hour_o   = hour_i;
      min_o    = min_sum[MIN_W-1:0];
      // A single carry suffices because ADD_MIN never exceeds one hour.
      if (min_sum >= MINS_PER_HOUR) begin
         min_o  = min_wrap[MIN_W-1:0];
         hour_o = (hour_i == MAX_HOUR) ? '0 : hour_i + 1'b1;
      end
   end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm clock controller: match on second ticks, ring with timeout, limited snoozes.
module alarm_scheduler
   import alarm_scheduler_pkg::*;
#(
   parameter int NUM_ALARMS     = 4,
   parameter int SNOOZE_MIN     = 5,
   parameter int RING_TIMEOUT_S = 60,
   parameter int MAX_SNOOZE     = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sec_tick,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   input  logic [SEC_W-1:0]  cur_sec,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [HOUR_W-1:0] cfg_hour,
   input  logic [MIN_W-1:0]  cfg_min,
   input  logic [SEC_W-1:0]  cfg_sec,
   input  logic              cfg_en,
   input  logic              snooze_btn,
   input  logic              dismiss_btn,
   output logic              ring_out,
   output logic [IDX_W-1:0]  ring_idx,
   output logic              snooze_active,
   output logic [1:0]        snooze_cnt
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(RING_TIMEOUT_S - 1);
   localparam logic [1:0] SNOOZE_LIMIT = 2'(MAX_SNOOZE);

   logic [HOUR_W-1:0] slot_hour_q [NUM_ALARMS];
   logic [MIN_W-1:0]  slot_min_q  [NUM_ALARMS];
   logic [SEC_W-1:0]  slot_sec_q  [NUM_ALARMS];
   logic              slot_en_q   [NUM_ALARMS];

   state_t            state_q,      state_d;
   logic [IDX_W-1:0]  ring_idx_q,   ring_idx_d;
   logic [1:0]        snooze_cnt_q, snooze_cnt_d;
   logic [7:0]        ring_tmr_q,   ring_tmr_d;
   logic [HOUR_W-1:0] tgt_hour_q,   tgt_hour_d;
   logic [MIN_W-1:0]  tgt_min_q,    tgt_min_d;
   logic [SEC_W-1:0]  tgt_sec_q,    tgt_sec_d;

   logic              match_any;
   logic [IDX_W-1:0]  match_idx;
   logic              cfg_ok;
   logic [HOUR_W-1:0] snz_hour;
   logic [MIN_W-1:0]  snz_min;

   time_add_min #(.ADD_MIN(SNOOZE_MIN)) u_snooze_add (
      .hour_i (cur_hour),
      .min_i  (cur_min),
      .hour_o (snz_hour),
      .min_o  (snz_min)
   );

   assign cfg_ok = cfg_we && time_valid(cfg_hour, cfg_min, cfg_sec)
                   && (int'(cfg_idx) < NUM_ALARMS);

   // Scan downward so the lowest matching slot is the one left standing.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (slot_en_q[i] && slot_hour_q[i] == cur_hour &&
             slot_min_q[i] == cur_min && slot_sec_q[i] == cur_sec) begin
            match_any = 1'b1;
            match_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ring_idx_d   = ring_idx_q;
      snooze_cnt_d = snooze_cnt_q;
      ring_tmr_d   = ring_tmr_q;
      tgt_hour_d   = tgt_hour_q;
      tgt_min_d    = tgt_min_q;
      tgt_sec_d    = tgt_sec_q;
      case (state_q)
         ST_IDLE: begin
            if (sec_tick && match_any) begin
               state_d      = ST_RING;
               ring_idx_d   = match_idx;
               snooze_cnt_d = '0;
               ring_tmr_d   = '0;
            end
         end
         ST_RING: begin
            if (dismiss_btn) begin
               state_d = ST_IDLE;
            end else if (snooze_btn && snooze_cnt_q < SNOOZE_LIMIT) begin
               state_d      = ST_SNOOZE;
               snooze_cnt_d = snooze_cnt_q + 1'b1;
               tgt_hour_d   = snz_hour;
               tgt_min_d    = snz_min;
               tgt_sec_d    = cur_sec;
            end else if (sec_tick) begin
               if (ring_tmr_q == TIMEOUT_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  ring_tmr_d = ring_tmr_q + 1'b1;
               end
            end
         end
         ST_SNOOZE: begin
            if (dismiss_btn) begin
               state_d = ST_IDLE;
            end else if (sec_tick && cur_hour == tgt_hour_q &&
                         cur_min == tgt_min_q && cur_sec == tgt_sec_q) begin
               state_d    = ST_RING;
               ring_tmr_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         ring_idx_q   <= '0;
         snooze_cnt_q <= '0;
         ring_tmr_q   <= '0;
         tgt_hour_q   <= '0;
         tgt_min_q    <= '0;
         tgt_sec_q    <= '0;
      end else begin
         state_q      <= state_d;
         ring_idx_q   <= ring_idx_d;
         snooze_cnt_q <= snooze_cnt_d;
         ring_tmr_q   <= ring_tmr_d;
         tgt_hour_q   <= tgt_hour_d;
         tgt_min_q    <= tgt_min_d;
         tgt_sec_q    <= tgt_sec_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            slot_hour_q[i] <= '0;
            slot_min_q[i]  <= '0;
            slot_sec_q[i]  <= '0;
            slot_en_q[i]   <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (cfg_ok && int'(cfg_idx) == i) begin
               slot_hour_q[i] <= cfg_hour;
               slot_min_q[i]  <= cfg_min;
               slot_sec_q[i]  <= cfg_sec;
               slot_en_q[i]   <= cfg_en;
            end
         end
      end
   end

   assign ring_out      = (state_q == ST_RING);
   assign snooze_active = (state_q == ST_SNOOZE);
   assign ring_idx      = ring_idx_q;
   assign snooze_cnt    = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler: directed scenarios plus a randomized run against an event-level model.
module tb_alarm_scheduler;

   localparam int NUM_ALARMS     = 4;
   localparam int SNOOZE_MIN     = 5;
   localparam int RING_TIMEOUT_S = 60;
   localparam int MAX_SNOOZE     = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sec_tick = 1'b0;
   logic [4:0] cur_hour = '0;
   logic [5:0] cur_min = '0;
   logic [5:0] cur_sec = '0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_idx = '0;
   logic [4:0] cfg_hour = '0;
   logic [5:0] cfg_min = '0;
   logic [5:0] cfg_sec = '0;
   logic       cfg_en = 1'b0;
   logic       snooze_btn = 1'b0;
   logic       dismiss_btn = 1'b0;
   logic       ring_out;
   logic [1:0] ring_idx;
   logic       snooze_active;
   logic [1:0] snooze_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alarm_scheduler #(
      .NUM_ALARMS     (NUM_ALARMS),
      .SNOOZE_MIN     (SNOOZE_MIN),
      .RING_TIMEOUT_S (RING_TIMEOUT_S),
      .MAX_SNOOZE     (MAX_SNOOZE)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .sec_tick      (sec_tick),
      .cur_hour      (cur_hour),
      .cur_min       (cur_min),
      .cur_sec       (cur_sec),
      .cfg_we        (cfg_we),
      .cfg_idx       (cfg_idx),
      .cfg_hour      (cfg_hour),
      .cfg_min       (cfg_min),
      .cfg_sec       (cfg_sec),
      .cfg_en        (cfg_en),
      .snooze_btn    (snooze_btn),
      .dismiss_btn   (dismiss_btn),
      .ring_out      (ring_out),
      .ring_idx      (ring_idx),
      .snooze_active (snooze_active),
      .snooze_cnt    (snooze_cnt)
   );

   // Event-level model: times kept as seconds of the day.
   int m_state;   // 0 idle, 1 ringing, 2 snoozing
   int m_idx, m_cnt, m_rung, m_target;
   int m_slot_sod [NUM_ALARMS];
   bit m_slot_en  [NUM_ALARMS];

   task automatic model_reset();
      m_state = 0; m_idx = 0; m_cnt = 0; m_rung = 0; m_target = 0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         m_slot_sod[i] = 0;
         m_slot_en[i]  = 1'b0;
      end
   endtask

   task automatic model_step();
      int now;
      int lo;
      now = int'(cur_hour) * 3600 + int'(cur_min) * 60 + int'(cur_sec);
      lo  = -1;
      if (sec_tick)
         for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (m_slot_en[i] && m_slot_sod[i] == now) lo = i;
      if (m_state == 0) begin
         if (lo >= 0) begin m_state = 1; m_idx = lo; m_cnt = 0; m_rung = 0; end
      end else if (m_state == 1) begin
         if (dismiss_btn) m_state = 0;
         else if (snooze_btn && m_cnt < MAX_SNOOZE) begin
            m_state  = 2;
            m_cnt    = m_cnt + 1;
            m_target = (now + SNOOZE_MIN * 60) % 86400;
         end else if (sec_tick) begin
            m_rung = m_rung + 1;
            if (m_rung >= RING_TIMEOUT_S) m_state = 0;
         end
      end else begin
         if (dismiss_btn) m_state = 0;
         else if (sec_tick && now == m_target) begin m_state = 1; m_rung = 0; end
      end
      if (cfg_we && cfg_hour <= 23 && cfg_min <= 59 && cfg_sec <= 59) begin
         m_slot_sod[cfg_idx] = int'(cfg_hour) * 3600 + int'(cfg_min) * 60 + int'(cfg_sec);
         m_slot_en[cfg_idx]  = cfg_en;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (reset_n) model_step();
      #1;
      sec_tick = 1'b0; snooze_btn = 1'b0; dismiss_btn = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic tick(input int h, input int m, input int s);
      cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
      sec_tick = 1'b1;
      step();
   endtask

   task automatic press(input bit snz, input bit dis);
      snooze_btn = snz; dismiss_btn = dis;
      step();
   endtask

   task automatic cfg_write(input int idx, input int h, input int m, input int s, input bit en);
      cfg_idx = 2'(idx); cfg_hour = 5'(h); cfg_min = 6'(m); cfg_sec = 6'(s); cfg_en = en;
      cfg_we = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      step(); step();
      n_cmp++; if (ring_out !== 1'b0) begin n_bad++; $display("FAIL reset_ring_out: got %0b want 0", ring_out); end
      n_cmp++; if (ring_idx !== 2'd0) begin n_bad++; $display("FAIL reset_ring_idx: got %0d want 0", ring_idx); end
      n_cmp++; if (snooze_active !== 1'b0) begin n_bad++; $display("FAIL reset_snooze_active: got %0b want 0", snooze_active); end
      n_cmp++; if (snooze_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_snooze_cnt: got %0d want 0", snooze_cnt); end
      reset_n = 1'b1;
      step();
      $display("test_reset done");
   endtask

   task automatic test_basic_ring();
      cfg_write(0, 7, 0, 0, 1'b1);
      tick(6, 59, 59);
      n_cmp++; if (ring_out !== 1'b0) begin n_bad++; $display("FAIL basic_early: ring_out=%0b want 0", ring_out); end
      tick(7, 0, 0);
      n_cmp++; if (ring_out !== 1'b1) begin n_bad++; $display("FAIL basic_ring: ring_out=%0b want 1", ring_out); end
      n_cmp++; if (ring_idx !== 2'd0) begin n_bad++; $display("FAIL basic_idx: ring_idx=%0d want 0", ring_idx); end
      n_cmp++; if (snooze_cnt !== 2'd0) begin n_bad++; $display("FAIL basic_cnt: snooze_cnt=%0d want 0", snooze_cnt); end
      press(1'b0, 1'b0);
      press(1'b1, 1'b1);
      for (int k = 1; k < RING_TIMEOUT_S; k++) tick(7, 0, k);
      n_cmp++; if (ring_out !== 1'b0) begin n_bad++; $display("FAIL basic_dismissed: ring_out=%0b want 0", ring_out); end
      // Fresh event, this time left to time out on its own.
      tick(7, 0, 0);
      for (int k = 1; k < RING_TIMEOUT_S; k++) tick(7, 0, k);
      n_cmp++; if (ring_out !== 1'b1) begin n_bad++; $display("FAIL timeout_59: ring_out=%0b want 1", ring_out); end
      tick(7, 1, 0);
      n_cmp++; if (ring_out !== 1'b0) begin n_bad++; $display("FAIL timeout_60: ring_out=%0b want 0", ring_out); end
      press(1'b1, 1'b0);
      n_cmp++; if (snooze_active !== 1'b0) begin n_bad++; $display("FAIL idle_button: snooze_active=%0b want 0", snooze_active); end
      $display("test_basic_ring done");
   endtask

   task automatic test_priority();
      cfg_write(1, 12, 30, 15, 1'b1);
      cfg_write(3, 12, 30, 15, 1'b1);
      tick(12, 30, 15);
      n_cmp++; if (ring_idx !== 2'd1 || ring_out !== 1'b1) begin n_bad++; $display("FAIL prio_idx: ring_out=%0b ring_idx=%0d want 1/1", ring_out, ring_idx); end
      tick(12, 30, 16);
      tick(12, 30, 15);
      n_cmp++; if (ring_idx !== 2'd1) begin n_bad++; $display("FAIL prio_held: ring_idx=%0d want 1", ring_idx); end
      press(1'b0, 1'b1);
      n_cmp++; if (ring_out !== 1'b0) begin n_bad++; $display("FAIL prio_dismiss: ring_out=%0b want 0", ring_out); end
      cfg_write(1, 12, 30, 15, 1'b0);
      cfg_write(3, 12, 30, 15, 1'b0);
      $display("test_priority done");
   endtask

   task automatic test_snooze_wrap();
      cfg_write(2, 23, 58, 10, 1'b1);
      tick(23, 58, 10);
      n_cmp++; if (ring_out !== 1'b1 || ring_idx !== 2'd2) begin n_bad++; $display("FAIL wrap_ring: ring_out=%0b ring_idx=%0d want 1/2", ring_out, ring_idx); end
      press(1'b1, 1'b0);
      n_cmp++; if (snooze_active !== 1'b1 || ring_out !== 1'b0) begin n_bad++; $display("FAIL wrap_snooze: snooze_active=%0b ring_out=%0b want 1/0", snooze_active, ring_out); end
      n_cmp++; if (snooze_cnt !== 2'd1) begin n_bad++; $display("FAIL wrap_cnt: snooze_cnt=%0d want 1", snooze_cnt); end
      tick(0, 3, 9);
      n_cmp++; if (snooze_active !== 1'b1) begin n_bad++; $display("FAIL wrap_early: snooze_active=%0b want 1", snooze_active); end
      tick(0, 3, 10);
      n_cmp++; if (ring_out !== 1'b1 || snooze_cnt !== 2'd1) begin n_bad++; $display("FAIL wrap_rering: ring_out=%0b snooze_cnt=%0d want 1/1", ring_out, snooze_cnt); end
      $display("test_snooze_wrap done");
   endtask

   task automatic test_max_snooze();
      press(1'b1, 1'b0);
      tick(0, 8, 10);
      n_cmp++; if (ring_out !== 1'b1 || snooze_cnt !== 2'd2) begin n_bad++; $display("FAIL max_second: ring_out=%0b snooze_cnt=%0d want 1/2", ring_out, snooze_cnt); end
      press(1'b1, 1'b0);
      tick(0, 13, 10);
      n_cmp++; if (ring_out !== 1'b1 || snooze_cnt !== 2'd3) begin n_bad++; $display("FAIL max_third: ring_out=%0b snooze_cnt=%0d want 1/3", ring_out, snooze_cnt); end
      press(1'b1, 1'b0);
      n_cmp++; if (ring_out !== 1'b1 || snooze_active !== 1'b0 || snooze_cnt !== 2'd3) begin n_bad++; $display("FAIL max_ignored: ring_out=%0b snooze_active=%0b snooze_cnt=%0d want 1/0/3", ring_out, snooze_active, snooze_cnt); end
      press(1'b0, 1'b1);
      n_cmp++; if (ring_out !== 1'b0) begin n_bad++; $display("FAIL max_dismiss: ring_out=%0b want 0", ring_out); end
      $display("test_max_snooze done");
   endtask

   task automatic test_both_buttons();
      tick(23, 58, 10);
      press(1'b1, 1'b1);
      n_cmp++; if (ring_out !== 1'b0 || snooze_active !== 1'b0) begin n_bad++; $display("FAIL both_btn: ring_out=%0b snooze_active=%0b want 0/0", ring_out, snooze_active); end
      cfg_write(0, 24, 0, 0, 1'b1);
      cfg_write(0, 8, 60, 0, 1'b1);
      tick(7, 0, 0);
      n_cmp++; if (ring_out !== 1'b1 || ring_idx !== 2'd0) begin n_bad++; $display("FAIL bad_cfg_kept: ring_out=%0b ring_idx=%0d want 1/0", ring_out, ring_idx); end
      cfg_write(0, 7, 0, 0, 1'b0);
      tick(7, 0, 1);
      n_cmp++; if (ring_out !== 1'b1) begin n_bad++; $display("FAIL disable_active: ring_out=%0b want 1", ring_out); end
      press(1'b0, 1'b1);
      cfg_write(0, 7, 0, 0, 1'b1);
      $display("test_both_buttons done");
   endtask

   task automatic test_reset_mid_ring();
      tick(7, 0, 0);
      n_cmp++; if (ring_out !== 1'b1) begin n_bad++; $display("FAIL rst_pre: ring_out=%0b want 1", ring_out); end
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_cmp++; if (ring_out !== 1'b0 || snooze_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_async: ring_out=%0b snooze_cnt=%0d want 0/0", ring_out, snooze_cnt); end
      step();
      reset_n = 1'b1;
      step();
      tick(7, 0, 0);
      n_cmp++; if (ring_out !== 1'b0) begin n_bad++; $display("FAIL rst_slot0: ring_out=%0b want 0", ring_out); end
      tick(23, 58, 10);
      n_cmp++; if (ring_out !== 1'b0) begin n_bad++; $display("FAIL rst_slot2: ring_out=%0b want 0", ring_out); end
      $display("test_reset_mid_ring done");
   endtask

   task automatic test_random();
      int h, m, s;
      for (int i = 0; i < NUM_ALARMS; i++)
         cfg_write(i, $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
      for (int c = 0; c < 4000; c++) begin
         if (m_state == 2 && $urandom_range(0, 3) == 0) begin
            h = m_target / 3600; m = (m_target / 60) % 60; s = m_target % 60;
         end else if ($urandom_range(0, 7) == 0) begin
            h = 23; m = $urandom_range(54, 59); s = $urandom_range(0, 2);
         end else begin
            h = $urandom_range(0, 1); m = $urandom_range(0, 2); s = $urandom_range(0, 2);
         end
         cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
         sec_tick    = ($urandom_range(0, 2) == 0);
         snooze_btn  = ($urandom_range(0, 7) == 0);
         dismiss_btn = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) begin
            cfg_we   = 1'b1;
            cfg_idx  = 2'($urandom_range(0, 3));
            cfg_hour = ($urandom_range(0, 5) == 0) ? 5'd24 : 5'($urandom_range(0, 1));
            cfg_min  = ($urandom_range(0, 5) == 0) ? 6'd60 : 6'($urandom_range(0, 2));
            cfg_sec  = 6'($urandom_range(0, 2));
            cfg_en   = ($urandom_range(0, 3) != 0);
         end
         step();
         n_cmp++; if (ring_out !== (m_state == 1)) begin n_bad++; $display("FAIL rand_ring_out c=%0d: got %0b want %0b", c, ring_out, (m_state == 1)); end
         n_cmp++; if (snooze_active !== (m_state == 2)) begin n_bad++; $display("FAIL rand_snooze_active c=%0d: got %0b want %0b", c, snooze_active, (m_state == 2)); end
         if (m_state != 0) begin
            n_cmp++; if (int'(ring_idx) != m_idx) begin n_bad++; $display("FAIL rand_ring_idx c=%0d: got %0d want %0d", c, ring_idx, m_idx); end
            n_cmp++; if (int'(snooze_cnt) != m_cnt) begin n_bad++; $display("FAIL rand_snooze_cnt c=%0d: got %0d want %0d", c, snooze_cnt, m_cnt); end
         end
      end
      $display("test_random done");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_ring();
      test_priority();
      test_snooze_wrap();
      test_max_snooze();
      test_both_buttons();
      test_reset_mid_ring();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 Parameter NUM_ALARMS, default 4: number of alarm slots.
REQ-002 Parameter SNOOZE_MIN, default 5: snooze length in minutes, range 1..59.
REQ-003 Parameter RING_TIMEOUT_S, default 60: auto-off after this many seconds of ringing, range 1..255.
REQ-004 Parameter MAX_SNOOZE, default 3: maximum snoozes per alarm event.
REQ-005 clk  input  1  system clock.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 sec_tick  input  1  single-cycle pulse; cur_* hold the new time in the same cycle.
REQ-008 cur_hour/cur_min/cur_sec  input  5/6/6  current 24-hour time.
REQ-009 cfg_we  input  1  slot write strobe.
REQ-010 cfg_idx  input  2  slot index.
REQ-011 cfg_hour/cfg_min/cfg_sec/cfg_en  input  5/6/6/1  slot write data.
REQ-012 snooze_btn, dismiss_btn  input  1 each  synchronous single-cycle pulses.
REQ-013 ring_out  output  1  alarm sounding.
REQ-014 ring_idx  output  2  slot that triggered the current event.
REQ-015 snooze_active  output  1  high in SNOOZE state.
REQ-016 snooze_cnt  output  2  snoozes used in the current event.

Function
REQ-017 States: IDLE, RING, SNOOZE; ring_out=1 only in RING; snooze_active=1 only in SNOOZE.
REQ-018 Slot write: on cfg_we, slot cfg_idx updated at next clk edge; rejected (slot unchanged) if cfg_hour>23, cfg_min>59 or cfg_sec>59.
REQ-019 Match: evaluated only in a cycle with sec_tick=1; slot matches if enabled and hour/min/sec equal cur_*.
REQ-020 IDLE -> RING on match; ring_idx = lowest matching index; snooze_cnt=0; ring timer=0; ring_out asserted the cycle after the sec_tick.
REQ-021 RING: ring timer increments per sec_tick; at RING_TIMEOUT_S -> IDLE.
REQ-022 RING + dismiss_btn -> IDLE next cycle.
REQ-023 RING + snooze_btn with snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt+1; target = cur time + SNOOZE_MIN minutes, seconds = cur_sec, minute wrap carries into hour, hour 23 wraps to 0.
REQ-024 snooze_btn with snooze_cnt==MAX_SNOOZE is ignored; ringing continues.
REQ-025 dismiss_btn and snooze_btn in the same cycle: dismiss wins.
REQ-026 SNOOZE: sec_tick with cur time == target -> RING; ring timer reset; ring_idx held.
REQ-027 SNOOZE + dismiss_btn -> IDLE.
REQ-028 Slot matches while in RING or SNOOZE are dropped, not queued.
REQ-029 Disabling or rewriting the active slot does not end the current event.
REQ-030 Buttons in IDLE have no effect.

Reset
REQ-031 On reset_n low, immediately: state IDLE; ring_out=0, ring_idx=0, snooze_active=0, snooze_cnt=0; all slots cleared with enable=0; timers and snooze target zeroed.
REQ-032 Reset asserted mid-RING or mid-SNOOZE aborts the event; no resumption after release.

Structure
REQ-033 Shared package holds the state enum, time field widths, and limits 23/59.
REQ-034 One sub-module, time_add_min: combinational hour/min + N minutes with 24-hour wrap, used for the snooze target.

Verification
REQ-035 Slot0 = 07:00:00 enabled; tick at 07:00:00 -> ring_out=1 next cycle, ring_idx=0; no buttons -> ring_out=0 after 60 ticks.
REQ-036 Slots 1 and 3 both = 12:30:15; tick -> ring_idx=1; slot 3 never rings during that event.
REQ-037 Ringing at 23:58:10; snooze -> SNOOZE, target 00:03:10; tick at 00:03:10 -> RING, snooze_cnt=1.
REQ-038 Snooze pressed 4 times across re-rings -> 4th ignored, snooze_cnt stays 3; dismiss -> IDLE.
REQ-039 Snooze and dismiss pressed in the same cycle -> IDLE, snooze_active=0; cfg write with hour=24 -> slot unchanged.
REQ-040 reset_n pulsed low during RING -> ring_out=0 immediately and all slots disabled; later tick at old alarm time -> no ring.
